// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and forwarding control plus data-memory wait
// handshake for a 5-stage RV32I pipeline.
//   clk, rst_n             clock, asynchronous active-low reset
//   id_*                   decoded ID-stage instruction fields
//   ex_br_taken            EX resolved a taken branch/jump this cycle
//   dmem_ready             data memory completes the current access
//   stall_if, stall_id     hold PC and IF/ID
//   flush_id, flush_ex     squash IF/ID, inject bubble into ID/EX
//   fwd_a, fwd_b           EX operand source: 00 regfile, 01 MEM, 10 WB
//   dmem_req               data-memory request for the access in MEM
//   mem_err                sticky access-timeout flag
//   stall_cnt              saturating count of stall_id cycles
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_we,
    input  logic             id_load,
    input  logic             id_store,
    input  logic             ex_br_taken,
    input  logic             dmem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tcnt;
    logic [4:0]    ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic          ex_we, ex_load, ex_store, mem_we, mem_load, mem_store, wb_we;
    logic          mem_acc, mem_stall, load_use, take_id;

    assign mem_acc   = mem_load | mem_store;
    assign dmem_req  = mem_acc && state != ERR;
    assign mem_stall = dmem_req && !dmem_ready;
    assign load_use  = id_valid && ex_load && ex_we && ex_rd != 5'd0 &&
                       ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    // A taken branch overrides load_use: the stalled instruction is wrong-path.
    assign stall_if  = mem_stall || (!ex_br_taken && load_use);
    assign stall_id  = stall_if;
    assign flush_id  = !mem_stall && ex_br_taken;
    assign flush_ex  = !mem_stall && (ex_br_taken || load_use);
    assign take_id   = id_valid && !flush_ex;
    // A load in MEM has no data yet, so only WB may forward its result.
    assign fwd_a = (mem_we && mem_rd != 5'd0 && mem_rd == ex_rs1 && !mem_load) ? 2'b01 :
                   (wb_we && wb_rd != 5'd0 && wb_rd == ex_rs1) ? 2'b10 : 2'b00;
    assign fwd_b = (mem_we && mem_rd != 5'd0 && mem_rd == ex_rs2 && !mem_load) ? 2'b01 :
                   (wb_we && wb_rd != 5'd0 && wb_rd == ex_rs2) ? 2'b10 : 2'b00;

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? ((mem_acc && !dmem_ready) ? WAIT : IDLE) :
                   (state == WAIT) ? (dmem_ready ? IDLE : (tcnt == TW'(TIMEOUT)) ? ERR : WAIT) :
                   IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // tcnt numbers the WAIT cycle currently in progress (1-based).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt      <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (state == IDLE)                    tcnt <= TW'(1);
            else if (state == WAIT && !dmem_ready) tcnt <= tcnt + TW'(1);
            mem_err   <= mem_err | (state_nx == ERR);
            stall_cnt <= stall_cnt + CNT_W'(stall_id && !(&stall_cnt));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {ex_rd, ex_rs1, ex_rs2, ex_we, ex_load, ex_store} <= '0;
            {mem_rd, mem_we, mem_load, mem_store}             <= '0;
            {wb_rd, wb_we}                                    <= '0;
        end else if (!mem_stall) begin
            wb_rd     <= mem_rd;
            wb_we     <= mem_we;
            mem_rd    <= ex_rd;
            mem_we    <= ex_we;
            mem_load  <= ex_load;
            mem_store <= ex_store;
            ex_rd     <= take_id ? id_rd  : 5'd0;
            ex_rs1    <= take_id ? id_rs1 : 5'd0;
            ex_rs2    <= take_id ? id_rs2 : 5'd0;
            ex_we     <= take_id && id_we;
            ex_load   <= take_id && id_load;
            ex_store  <= take_id && id_store;
        end
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core.
- Sits beside the decoder. Takes decoded ID-stage fields (rd, rs1/rs2, we, load, store, branch/jump class) and keeps its own shadow copies of the EX, MEM and WB stage destination info.
- Generates stall, flush and forwarding selects, and runs the data-memory wait handshake for loads and stores in MEM.

Parameters:
- TIMEOUT, 16, maximum cycles spent in WAIT before declaring a memory error.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  5 each  ID source register indices
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1/rs2
- id_rd  in  5  ID destination register
- id_we  in  1  ID writes the register file
- id_load, id_store  in  1 each  ID is a load/store
- ex_br_taken  in  1  EX resolved a taken branch, jal or jalr this cycle
- dmem_ready  in  1  data memory completes the current access
- stall_if, stall_id  out  1 each  hold PC and the IF/ID register
- flush_id  out  1  squash the IF/ID register
- flush_ex  out  1  load a bubble into the ID/EX register
- fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 01 MEM result, 10 WB result
- dmem_req  out  1  data-memory access request
- mem_err  out  1  sticky: an access timed out
- stall_cnt  out  CNT_W  count of cycles with stall_id=1, saturating

Behaviour:
- Reset, asynchronous on rst_n=0:
  - All shadow slots invalid (we=0, load=0, store=0, rd=0, rs=0).
  - FSM in IDLE; mem_err=0; stall_cnt=0.
  - Combinational outputs then evaluate to 0 / 00.
  - Reset mid-WAIT aborts the access immediately.
- Shadow slots:
  - EX slot holds rd, rs1, rs2, we, load, store.
  - MEM and WB slots hold rd, we, load, store.
- Advance rule: adv = !mem_stall. On adv the slots shift WB<=MEM, MEM<=EX. EX takes the ID fields if id_valid and flush_ex=0, otherwise a bubble (all zero).
- When adv=0, every slot holds its value.
- load_use, combinational, is 1 when all of these hold:
  - id_valid=1;
  - EX.load=1, EX.we=1 and EX.rd!=0;
  - (id_use_rs1 and id_rs1==EX.rd) or (id_use_rs2 and id_rs2==EX.rd).
- Priority (highest first):
  1. mem_stall: stall_if=stall_id=1, flush_id=flush_ex=0.
  2. ex_br_taken: flush_id=1, flush_ex=1, stall_if=stall_id=0. The wrong-path ID instruction is squashed even if load_use is asserted.
  3. load_use: stall_if=stall_id=1, flush_ex=1. This gives exactly one bubble.
  4. Otherwise: all 0.
- Forwarding for fwd_a, using EX.rs1 (fwd_b identical using EX.rs2):
  - 01 if MEM.we, MEM.rd!=0, MEM.rd==EX.rs1 and !MEM.load.
  - Else 10 if WB.we, WB.rd!=0, WB.rd==EX.rs1.
  - Else 00.
  - MEM takes precedence over WB.
  - Register x0 never forwards.
- Memory FSM states IDLE, WAIT, ERR:
  - mem_acc = MEM.load | MEM.store.
  - dmem_req = mem_acc while in IDLE or WAIT; 0 in ERR.
  - mem_stall = dmem_req & !dmem_ready.
  - IDLE: if mem_acc and !dmem_ready, go to WAIT and clear the counter to 1. Zero-wait accesses (ready in the same cycle) stay in IDLE.
  - WAIT: if dmem_ready, go to IDLE. Otherwise the counter increments; when it reaches TIMEOUT, go to ERR and set mem_err=1.
  - ERR: one cycle. mem_stall=0, so the access retires as if complete; then go to IDLE.
  - mem_err is cleared only by reset.
- stall_cnt increments on every cycle with stall_id=1 and saturates at all-ones.

Test Plan:
- Reset with rst_n=0 mid-WAIT, then release -> dmem_req=0, all stalls and flushes 0, fwd 00, stall_cnt=0, mem_err=0.
- lw x5 followed by add x6,x5,x1 -> one cycle with stall_if=stall_id=flush_ex=1; next cycle no stall; when add reaches EX, fwd_a=10.
- add x3,... then sub x4,x3,x3 back-to-back -> in sub's EX cycle fwd_a=fwd_b=01. With rd=x0 instead -> fwd 00.
- ex_br_taken=1 in the same cycle load_use would fire -> flush_id=1, flush_ex=1, stall_if=0.
- Load in MEM with dmem_ready low for 3 cycles -> dmem_req=1 and stalls held for 3 cycles, shadows frozen; ready on the 4th cycle releases; stall_cnt increases by 3.
- dmem_ready held low with TIMEOUT=16 -> ERR after 16 WAIT cycles, mem_err=1 sticky, stalls drop, FSM returns to IDLE.
